// File: rtl/trigger_capture.sv
// -----------------------------------------------------------------------------
// trigger_capture
//
// Circular-buffer waveform capture with a level/slope trigger. After an arm
// pulse the block records PRE_TRIG samples, then waits for a threshold crossing,
// then records the remainder of the buffer. It then freezes so the capture can
// be read back relative to the oldest captured sample.
//
// Ports
//   clk100      : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   sample_en   : one-cycle strobe, data_in valid
//   data_in     : 8-bit unsigned sample
//   trig_level  : 8-bit unsigned trigger threshold (used live, not latched)
//   trig_slope  : 0 = rising crossing, 1 = falling crossing
//   arm         : one-cycle pulse, starts or restarts a capture
//   rd_addr     : read index relative to the oldest captured sample
//   rd_data     : registered read data, one clock after rd_addr
//   busy        : capture in progress (PRE, WAIT_TRIG, POST)
//   done        : capture complete, buffer frozen
//   trig_forced : last capture was auto-triggered
//
// Build option
//   TRIG_AUTO_EN : when defined, WAIT_TRIG forces a trigger after AUTO_TIMEOUT
//                  strobes without a real crossing.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | after reset, no capture, strobes ignored
// S_PRE     | filling the PRE_TRIG pre-trigger samples
// S_WAIT    | recording continuously, looking for a trigger crossing
// S_POST    | recording the post-trigger samples
// S_DONE    | capture complete, strobes ignored, buffer frozen
// -----------------------------------------------------------------------------
module trigger_capture #(
    parameter int DEPTH_LOG2   = 9,
    parameter int PRE_TRIG     = 128,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic                  clk100,
    input  logic                  rst_n,
    input  logic                  sample_en,
    input  logic [7:0]            data_in,
    input  logic [7:0]            trig_level,
    input  logic                  trig_slope,
    input  logic                  arm,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [7:0]            rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  trig_forced
);

    localparam int DEPTH  = 2 ** DEPTH_LOG2;
    localparam int POST_N = DEPTH - PRE_TRIG;
    localparam int CW     = DEPTH_LOG2 + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   start_ptr_q, start_ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [7:0]              prev_q, prev_d;
    logic                    prev_valid_q, prev_valid_d;
    logic [7:0]              rd_data_q;
    logic                    wr_en;
    logic                    capturing;
    logic                    real_hit;
    logic [DEPTH_LOG2-1:0]   rd_idx;

    logic [7:0] mem [DEPTH];

`ifdef TRIG_AUTO_EN
    localparam int TO_W = (AUTO_TIMEOUT < 2) ? 1 : $clog2(AUTO_TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            forced_q, forced_d;
    logic            auto_hit;
`endif

    assign capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
    assign busy      = capturing;
    assign done      = (state_q == S_DONE);
    assign rd_data   = rd_data_q;
    assign rd_idx    = start_ptr_q + rd_addr;

    // Crossing test against the previous written sample; threshold and slope
    // are taken live on every strobe.
    always_comb begin
        real_hit = 1'b0;
        if (prev_valid_q) begin
            if (trig_slope) begin
                real_hit = (prev_q > trig_level) && (data_in <= trig_level);
            end else begin
                real_hit = (prev_q < trig_level) && (data_in >= trig_level);
            end
        end
    end

`ifdef TRIG_AUTO_EN
    assign auto_hit    = (to_cnt_q == TO_W'(AUTO_TIMEOUT - 1));
    assign trig_forced = forced_q;
`else
    // Auto-trigger is compiled out. AUTO_TIMEOUT is never negative, so this is
    // a constant 0 that still references the parameter.
    assign trig_forced = (AUTO_TIMEOUT < 0);
`endif

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        start_ptr_d  = start_ptr_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        wr_en        = 1'b0;
`ifdef TRIG_AUTO_EN
        to_cnt_d     = to_cnt_q;
        forced_d     = forced_q;
`endif

        if (arm) begin
            // A strobe in the arm cycle is dropped on purpose.
            state_d      = S_PRE;
            wr_ptr_d     = '0;
            cnt_d        = '0;
            prev_valid_d = 1'b0;
`ifdef TRIG_AUTO_EN
            to_cnt_d     = '0;
            forced_d     = 1'b0;
`endif
        end else if (sample_en && capturing) begin
            wr_en        = 1'b1;
            wr_ptr_d     = wr_ptr_q + DEPTH_LOG2'(1);
            prev_d       = data_in;
            prev_valid_d = 1'b1;

            case (state_q)
                S_PRE: begin
                    if (cnt_q == CW'(PRE_TRIG - 1)) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
`ifdef TRIG_AUTO_EN
                        to_cnt_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_WAIT: begin
`ifdef TRIG_AUTO_EN
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (real_hit || auto_hit) begin
                        forced_d = !real_hit;
`else
                    if (real_hit) begin
`endif
                        // The trigger sample is the first post sample.
                        start_ptr_d = wr_ptr_q - DEPTH_LOG2'(PRE_TRIG);
                        cnt_d       = CW'(1);
                        state_d     = (POST_N == 1) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (cnt_q == CW'(POST_N - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            start_ptr_q  <= '0;
            cnt_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            rd_data_q    <= '0;
`ifdef TRIG_AUTO_EN
            to_cnt_q     <= '0;
            forced_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            start_ptr_q  <= start_ptr_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            rd_data_q    <= mem[rd_idx];
`ifdef TRIG_AUTO_EN
            to_cnt_q     <= to_cnt_d;
            forced_q     <= forced_d;
`endif
        end
    end

    // Sample memory is deliberately not reset.
    always_ff @(posedge clk100) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_trigger_capture.sv
module tb_trigger_capture;

    localparam int DL2 = 9;

    logic           clk100 = 1'b0;
    logic           rst_n;
    logic           sample_en;
    logic [7:0]     data_in;
    logic [7:0]     trig_level;
    logic           trig_slope;
    logic           arm;
    logic [DL2-1:0] rd_addr;

    logic [7:0]     rd_data_a, rd_data_b;
    logic           busy_a, busy_b;
    logic           done_a, done_b;
    logic           forced_a, forced_b;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    int wave_i;
    int wave_mode;

    // Main instance: default timeout, so the auto-trigger never interferes.
    trigger_capture #(.DEPTH_LOG2(DL2), .PRE_TRIG(128), .AUTO_TIMEOUT(65535)) dut (
        .clk100(clk100), .rst_n(rst_n), .sample_en(sample_en), .data_in(data_in),
        .trig_level(trig_level), .trig_slope(trig_slope), .arm(arm), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .busy(busy_a), .done(done_a), .trig_forced(forced_a)
    );

    // Short-timeout instance for the auto-trigger scenario.
    trigger_capture #(.DEPTH_LOG2(DL2), .PRE_TRIG(128), .AUTO_TIMEOUT(16)) dut_to (
        .clk100(clk100), .rst_n(rst_n), .sample_en(sample_en), .data_in(data_in),
        .trig_level(trig_level), .trig_slope(trig_slope), .arm(arm), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .busy(busy_b), .done(done_b), .trig_forced(forced_b)
    );

    always #5 clk100 = ~clk100;

    function automatic logic [7:0] wave_val(input int mode, input int i);
        int p;
        case (mode)
            0: return 8'(i % 256);
            1: begin
                p = i % 170;
                if (p < 86) return 8'(3 * p);
                else        return 8'(3 * (170 - p));
            end
            default: return 8'd50;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        wave_i = 0;
    endtask

    task automatic strobe();
        sample_en = 1'b1;
        data_in   = wave_val(wave_mode, wave_i);
        wave_i++;
        tick();
        sample_en = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rst_n = 1'b0;
        repeat (3) tick();
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_a); end
        total++; if (forced_b !== 1'b0) begin bad++; $display("FAIL reset_forced got=%b exp=0", forced_b); end
        got = rd_data_a;
        total++; if (got !== 8'd0) begin bad++; $display("FAIL reset_rd_data got=%0d exp=0", got); end
        rst_n = 1'b1;
        repeat (2) tick();
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy_a); end
    endtask

    task automatic test_ramp_rising();
        int n;
        logic [7:0] got, e;
        wave_mode = 0; trig_level = 8'd100; trig_slope = 1'b0;
        do_arm();
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL ramp_busy_after_arm got=%b exp=1", busy_a); end
        n = 0;
        while (!done_a && n < 2000) begin strobe(); n++; end
        total++; if (n !== 740) begin bad++; $display("FAIL ramp_done_strobes got=%0d exp=740", n); end
        total++; if (forced_a !== 1'b0) begin bad++; $display("FAIL ramp_forced got=%b exp=0", forced_a); end
        // strobes after done must not disturb the frozen buffer
        repeat (5) strobe();
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL ramp_done_hold got=%b exp=1", done_a); end
        for (int k = 0; k < 512; k++) begin
            rd_addr = DL2'(k);
            exp_q.push_back(8'((k + 228) % 256));
            tick();
            got = rd_data_a;
            e = exp_q.pop_front();
            total++; if (got !== e) begin bad++; $display("FAIL ramp_read addr=%0d got=%0d exp=%0d", k, got, e); end
        end
    endtask

    task automatic test_triangle_falling();
        int n;
        logic [7:0] got, e;
        int addrs[3] = '{128, 127, 0};
        logic [7:0] exps[3] = '{8'd198, 8'd201, 8'd72};
        wave_mode = 1; trig_level = 8'd200; trig_slope = 1'b1;
        do_arm();
        n = 0;
        while (!done_a && n < 2000) begin strobe(); n++; end
        total++; if (n !== 658) begin bad++; $display("FAIL tri_done_strobes got=%0d exp=658", n); end
        for (int j = 0; j < 3; j++) begin
            rd_addr = DL2'(addrs[j]);
            exp_q.push_back(exps[j]);
            tick();
            got = rd_data_a;
            e = exp_q.pop_front();
            total++; if (got !== e) begin bad++; $display("FAIL tri_read addr=%0d got=%0d exp=%0d", addrs[j], got, e); end
        end
    endtask

    task automatic test_auto_timeout();
        int n;
        wave_mode = 2; trig_level = 8'd100; trig_slope = 1'b0;
        do_arm();
`ifdef TRIG_AUTO_EN
        n = 0;
        while (!done_b && n < 2000) begin strobe(); n++; end
        total++; if (n !== 527) begin bad++; $display("FAIL auto_done_strobes got=%0d exp=527", n); end
        total++; if (forced_b !== 1'b1) begin bad++; $display("FAIL auto_forced got=%b exp=1", forced_b); end
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL auto_long_to_busy got=%b exp=1", busy_a); end
`else
        n = 0;
        repeat (700) begin strobe(); n++; end
        total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL noauto_busy got=%b exp=1 after %0d", busy_b, n); end
        total++; if (done_b !== 1'b0) begin bad++; $display("FAIL noauto_done got=%b exp=0", done_b); end
        total++; if (forced_b !== 1'b0) begin bad++; $display("FAIL noauto_forced got=%b exp=0", forced_b); end
`endif
    endtask

    task automatic test_rearm();
        int n;
        logic [7:0] got, e;
        wave_mode = 0; trig_level = 8'd100; trig_slope = 1'b0;
        do_arm();
        total++; if (forced_b !== 1'b0) begin bad++; $display("FAIL arm_clears_forced got=%b exp=0", forced_b); end
        // trigger is strobe 357; strobe 656 is post sample 300
        repeat (656) strobe();
        total++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin
            bad++; $display("FAIL rearm_in_post busy=%b done=%b exp busy=1 done=0", busy_a, done_a);
        end
        do_arm();
        total++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin
            bad++; $display("FAIL rearm_after_arm busy=%b done=%b exp busy=1 done=0", busy_a, done_a);
        end
        n = 0;
        while (!done_a && n < 2000) begin strobe(); n++; end
        total++; if (n !== 740) begin bad++; $display("FAIL rearm_done_strobes got=%0d exp=740", n); end
        for (int k = 127; k <= 128; k++) begin
            rd_addr = DL2'(k);
            exp_q.push_back(8'((k + 228) % 256));
            tick();
            got = rd_data_a;
            e = exp_q.pop_front();
            total++; if (got !== e) begin bad++; $display("FAIL rearm_read addr=%0d got=%0d exp=%0d", k, got, e); end
        end
    endtask

    task automatic test_arm_collision();
        int n;
        logic [7:0] got, e;
        wave_mode = 0; trig_level = 8'd100; trig_slope = 1'b0;
        do_arm();
        repeat (10) strobe();
        // arm together with a strobe carrying a marker value
        arm = 1'b1; sample_en = 1'b1; data_in = 8'hEE;
        tick();
        arm = 1'b0; sample_en = 1'b0; wave_i = 0;
        repeat (3) tick();
        n = 0;
        while (!done_a && n < 2000) begin strobe(); n++; end
        total++; if (n !== 740) begin bad++; $display("FAIL collide_done_strobes got=%0d exp=740", n); end
        rd_addr = DL2'(0);
        exp_q.push_back(8'd228);
        tick();
        got = rd_data_a;
        e = exp_q.pop_front();
        total++; if (got !== e) begin bad++; $display("FAIL collide_read0 got=%0d exp=%0d", got, e); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        wave_mode = 0; trig_level = 8'd100; trig_slope = 1'b0;
        do_arm();
        repeat (140) strobe();
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy_a); end
        #2;
        rst_n = 1'b0;
        #1;
        got = rd_data_a;
        total++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            bad++; $display("FAIL mid_async busy=%b done=%b exp busy=0 done=0", busy_a, done_a);
        end
        total++; if (got !== 8'd0) begin bad++; $display("FAIL mid_rd_data got=%0d exp=0", got); end
        tick();
        rst_n = 1'b1;
        repeat (300) strobe();
        total++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            bad++; $display("FAIL mid_stays_idle busy=%b done=%b exp busy=0 done=0", busy_a, done_a);
        end
    endtask

    initial begin
        rst_n = 1'b0; sample_en = 1'b0; data_in = '0; trig_level = '0;
        trig_slope = 1'b0; arm = 1'b0; rd_addr = '0; wave_i = 0; wave_mode = 0;
        test_reset();
        test_ramp_rising();
        test_triangle_falling();
        test_auto_timeout();
        test_rearm();
        test_arm_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
